hall_conditioner: RTL and testbench

Conditions the three raw Hall-effect sensor inputs of one BLDC motor and drives the clean `h[2:0]` code consumed by the commutation logic downstream. Synchronises and debounces the sensors, classifies each commutation step as forward, reverse or illegal, and measures the clock-cycle period between steps for the speed loop. One instance per motor, in the same clock domain as the PWM generator.

---
 rtl/hall_pkg.sv | 68 ++++++
 rtl/hall_sync_debounce.sv | 62 ++++++
 rtl/hall_conditioner.sv | 119 +++++++++++
 tb/tb_hall_conditioner.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hall_pkg.sv
// hall_pkg: shared Hall-sensor definitions for the conditioner and the
// commutation logic.
//   HALL_INV0 / HALL_INV1 : the two codes a healthy 120-degree sensor set never shows
//   hall_fwd_next/prev    : neighbours of a code in the forward sequence
//                           100 -> 110 -> 010 -> 011 -> 001 -> 101 -> 100
//   hall_is_valid         : code is neither 000 nor 111
//   hall_classify         : classifies the step old -> new
package hall_pkg;

    localparam logic [2:0] HALL_INV0 = 3'b000;
    localparam logic [2:0] HALL_INV1 = 3'b111;

    // STEP_NONE: the step started from an invalid code and is not judged.
    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_BAD
    } step_e;

    // Invalid codes map to themselves, so they never match a real neighbour.
    function automatic logic [2:0] hall_fwd_next(input logic [2:0] code);
        logic [2:0] r;
        case (code)
            3'b100:  r = 3'b110;
            3'b110:  r = 3'b010;
            3'b010:  r = 3'b011;
            3'b011:  r = 3'b001;
            3'b001:  r = 3'b101;
            3'b101:  r = 3'b100;
            default: r = code;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] hall_fwd_prev(input logic [2:0] code);
        logic [2:0] r;
        case (code)
            3'b100:  r = 3'b101;
            3'b110:  r = 3'b100;
            3'b010:  r = 3'b110;
            3'b011:  r = 3'b010;
            3'b001:  r = 3'b011;
            3'b101:  r = 3'b001;
            default: r = code;
        endcase
        return r;
    endfunction

    function automatic logic hall_is_valid(input logic [2:0] code);
        return (code != HALL_INV0) && (code != HALL_INV1);
    endfunction

    function automatic step_e hall_classify(input logic [2:0] old_code,
                                            input logic [2:0] new_code);
        step_e r;
        if (!hall_is_valid(old_code))
            r = STEP_NONE;
        else if (new_code == hall_fwd_next(old_code))
            r = STEP_FWD;
        else if (new_code == hall_fwd_prev(old_code))
            r = STEP_REV;
        else
            r = STEP_BAD;
        return r;
    endfunction

endpackage

// File: rtl/hall_sync_debounce.sv
// hall_sync_debounce: two-flop synchroniser, candidate register and debounce
// counter for the three Hall pins.
//   clk, rst_n : clock, synchronous active-low reset
//   hall_raw   : asynchronous sensor pins {H2,H1,H0}
//   h          : debounced code (registered)
//   hall_edge  : one-cycle pulse in the cycle h holds a new value
//   cand       : current candidate code (the value h is about to take)
//   commit     : high in the cycle whose rising edge loads cand into h;
//                lets the parent judge the step at the same edge
module hall_sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] hall_raw,
    output logic [2:0] h,
    output logic       hall_edge,
    output logic [2:0] cand,
    output logic       commit
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [2:0] s1;
    logic [2:0] s2;
    logic [7:0] cnt;

    // Candidate stable for DEBOUNCE_CYCLES comparisons and differs from h.
    assign commit = (s2 == cand) && (cand != h) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= 3'b000;
            s2        <= 3'b000;
            cand      <= 3'b000;
            h         <= 3'b000;
            cnt       <= 8'd0;
            hall_edge <= 1'b0;
        end else begin
            s1        <= hall_raw;
            s2        <= s1;
            hall_edge <= 1'b0;
            if (s2 != cand) begin
                // Any change restarts the stability window.
                cand <= s2;
                cnt  <= 8'd0;
            end else if (cand != h) begin
                if (cnt == CNT_LAST) begin
                    h         <= cand;
                    hall_edge <= 1'b1;
                    cnt       <= 8'd0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                // Settled back on h: a pending change is dropped silently.
                cnt <= 8'd0;
            end
        end
    end

endmodule

// File: rtl/hall_conditioner.sv
// hall_conditioner: Hall sensor conditioning for one BLDC motor.
// Debounces the raw pins, classifies each step of the debounced code as
// forward / reverse / illegal and measures the cycle spacing of legal steps.
//   clk, rst_n   : clock, synchronous active-low reset
//   hall_raw     : asynchronous sensor pins {H2,H1,H0}
//   h            : debounced Hall code
//   hall_valid   : h is neither 000 nor 111
//   hall_edge    : one-cycle pulse when h changes
//   dir          : 1 forward, 0 reverse (legal steps only)
//   fault        : one-cycle pulse on an illegal step
//   stalled      : period counter saturated
//   period       : cycles between the last two legal steps
//   period_valid : one-cycle pulse when period updates
// Build option: HALL_PERIOD_EN builds the period counter; when undefined,
// period, period_valid and stalled are tied to 0.
module hall_conditioner
    import hall_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PERIOD_W        = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          hall_raw,
    output logic [2:0]          h,
    output logic                hall_valid,
    output logic                hall_edge,
    output logic                dir,
    output logic                fault,
    output logic                stalled,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid
);

    logic [2:0] cand;
    logic       commit;
    step_e      step;

    hall_sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .hall_raw (hall_raw),
        .h        (h),
        .hall_edge(hall_edge),
        .cand     (cand),
        .commit   (commit)
    );

    // h still holds the old code while commit is high, cand the new one.
    always_comb step = hall_classify(h, cand);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hall_valid <= 1'b0;
            dir        <= 1'b1;
            fault      <= 1'b0;
        end else begin
            fault <= 1'b0;
            if (commit) begin
                hall_valid <= hall_is_valid(cand);
                case (step)
                    STEP_FWD: dir   <= 1'b1;
                    STEP_REV: dir   <= 1'b0;
                    STEP_BAD: fault <= 1'b1;
                    default:  ;
                endcase
            end
        end
    end

`ifdef HALL_PERIOD_EN
    localparam logic [PERIOD_W-1:0] PC_MAX = '1;
    localparam logic [PERIOD_W-1:0] PC_ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] pc;
    logic                prev_legal;
    logic                legal;

    assign legal = (step == STEP_FWD) || (step == STEP_REV);

    // pc restarts on the cycle after the commit edge, so at the next commit
    // it holds (distance - 1); stalled mirrors pc == PC_MAX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc           <= PC_MAX;
            stalled      <= 1'b1;
            period       <= '0;
            period_valid <= 1'b0;
            prev_legal   <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (hall_edge) begin
                pc      <= PC_ONE;
                stalled <= 1'b0;
            end else if (pc != PC_MAX) begin
                pc      <= pc + PC_ONE;
                stalled <= ((pc + PC_ONE) == PC_MAX);
            end else begin
                stalled <= 1'b1;
            end

            if (commit) begin
                prev_legal <= legal;
                if (legal && prev_legal && !stalled) begin
                    period       <= pc + PC_ONE;
                    period_valid <= 1'b1;
                end
            end
        end
    end
`else
    assign stalled      = 1'b0;
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_hall_conditioner.sv
module tb_hall_conditioner;

    localparam int D = 16;
`ifdef HALL_PERIOD_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default widths. Instance B: 8-bit period for stall tests.
    logic        rst_n_a, rst_n_b;
    logic [2:0]  raw_a, raw_b;
    logic [2:0]  h_a, h_b;
    logic        hv_a, he_a, dir_a, fault_a, st_a, pv_a;
    logic        hv_b, he_b, dir_b, fault_b, st_b, pv_b;
    logic [19:0] per_a;
    logic [7:0]  per_b;

    hall_conditioner #(.DEBOUNCE_CYCLES(D), .PERIOD_W(20)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .hall_raw(raw_a), .h(h_a),
        .hall_valid(hv_a), .hall_edge(he_a), .dir(dir_a), .fault(fault_a),
        .stalled(st_a), .period(per_a), .period_valid(pv_a)
    );

    hall_conditioner #(.DEBOUNCE_CYCLES(D), .PERIOD_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .hall_raw(raw_b), .h(h_b),
        .hall_valid(hv_b), .hall_edge(he_b), .dir(dir_b), .fault(fault_b),
        .stalled(st_b), .period(per_b), .period_valid(pv_b)
    );

    int checks = 0;
    int passed = 0;

    // Pulse counters, sampled 1 time unit after each rising edge.
    int edges_a = 0, faults_a = 0, pvs_a = 0;
    int pvs_b = 0;
    always @(posedge clk) begin
        #1;
        if (he_a === 1'b1) edges_a = edges_a + 1;
        if (fault_a === 1'b1) faults_a = faults_a + 1;
        if (pv_a === 1'b1) pvs_a = pvs_a + 1;
        if (pv_b === 1'b1) pvs_b = pvs_b + 1;
    end

    // Drive a new raw code on a falling edge and let 'gap' rising edges pass.
    task automatic step_a(input logic [2:0] code, input int gap);
        raw_a = code;
        repeat (gap) @(negedge clk);
    endtask

    task automatic step_b(input logic [2:0] code, input int gap);
        raw_b = code;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n_a = 1'b0; raw_a = 3'b101;
        repeat (5) @(negedge clk);
        checks++; if (h_a !== 3'b000) $display("FAIL reset_h: got %b want 000", h_a); else passed++;
        checks++; if ({hv_a, he_a, fault_a, pv_a} !== 4'b0000)
            $display("FAIL reset_pulses: got %b want 0000", {hv_a, he_a, fault_a, pv_a}); else passed++;
        checks++; if (dir_a !== 1'b1) $display("FAIL reset_dir: got %b want 1", dir_a); else passed++;
        checks++; if (st_a !== PEN) $display("FAIL reset_stalled: got %b want %b", st_a, PEN); else passed++;
        checks++; if (per_a !== 20'd0) $display("FAIL reset_period: got %0d want 0", per_a); else passed++;
    endtask

    task automatic test_acquire;
        int e0, f0, p0;
        e0 = edges_a; f0 = faults_a; p0 = pvs_a;
        rst_n_a = 1'b1; raw_a = 3'b100;
        repeat (D + 2) @(negedge clk);
        checks++; if (h_a !== 3'b000) $display("FAIL acq_early: got %b want 000", h_a); else passed++;
        @(negedge clk);
        checks++; if (h_a !== 3'b100) $display("FAIL acq_h: got %b want 100", h_a); else passed++;
        checks++; if (he_a !== 1'b1) $display("FAIL acq_edge: got %b want 1", he_a); else passed++;
        checks++; if (hv_a !== 1'b1) $display("FAIL acq_valid: got %b want 1", hv_a); else passed++;
        repeat (5) @(negedge clk);
        checks++; if (edges_a - e0 !== 1) $display("FAIL acq_edge_count: got %0d want 1", edges_a - e0); else passed++;
        checks++; if ((faults_a - f0) + (pvs_a - p0) !== 0)
            $display("FAIL acq_fault_pv: got %0d want 0", (faults_a - f0) + (pvs_a - p0)); else passed++;
    endtask

    task automatic test_glitch;
        int e0;
        e0 = edges_a;
        step_a(3'b110, 10);
        step_a(3'b100, 30);
        // D samples is still one short of acceptance.
        step_a(3'b110, D);
        step_a(3'b100, 30);
        checks++; if (h_a !== 3'b100) $display("FAIL glitch_h: got %b want 100", h_a); else passed++;
        checks++; if (edges_a - e0 !== 0) $display("FAIL glitch_edges: got %0d want 0", edges_a - e0); else passed++;
    endtask

    task automatic test_forward_reverse;
        int p0;
        p0 = pvs_a;
        step_a(3'b110, 1000);
        checks++; if (dir_a !== 1'b1) $display("FAIL fwd1_dir: got %b want 1", dir_a); else passed++;
        checks++; if (pvs_a - p0 !== 0) $display("FAIL fwd1_pv: got %0d want 0", pvs_a - p0); else passed++;
        step_a(3'b010, 1000);
        checks++; if (per_a !== (PEN ? 20'd1000 : 20'd0)) $display("FAIL fwd2_period: got %0d want %0d", per_a, PEN ? 1000 : 0); else passed++;
        step_a(3'b011, 1000);
        checks++; if (pvs_a - p0 !== (PEN ? 2 : 0)) $display("FAIL fwd3_pv: got %0d want %0d", pvs_a - p0, PEN ? 2 : 0); else passed++;
        checks++; if (h_a !== 3'b011) $display("FAIL fwd3_h: got %b want 011", h_a); else passed++;
        step_a(3'b010, 1000);
        checks++; if (dir_a !== 1'b0) $display("FAIL rev1_dir: got %b want 0", dir_a); else passed++;
        step_a(3'b110, 500);
        step_a(3'b100, 500);
        checks++; if (dir_a !== 1'b0) $display("FAIL rev3_dir: got %b want 0", dir_a); else passed++;
        checks++; if (per_a !== (PEN ? 20'd500 : 20'd0)) $display("FAIL rev3_period: got %0d want %0d", per_a, PEN ? 500 : 0); else passed++;
        checks++; if (pvs_a - p0 !== (PEN ? 5 : 0)) $display("FAIL rev_pv: got %0d want %0d", pvs_a - p0, PEN ? 5 : 0); else passed++;
    endtask

    task automatic test_skip_fault;
        int f0, p0;
        f0 = faults_a; p0 = pvs_a;
        step_a(3'b010, 300);
        checks++; if (faults_a - f0 !== 1) $display("FAIL skip_fault: got %0d want 1", faults_a - f0); else passed++;
        checks++; if (dir_a !== 1'b0) $display("FAIL skip_dir: got %b want 0", dir_a); else passed++;
        checks++; if (per_a !== (PEN ? 20'd500 : 20'd0)) $display("FAIL skip_period: got %0d want %0d", per_a, PEN ? 500 : 0); else passed++;
        step_a(3'b011, 300);
        checks++; if (dir_a !== 1'b1) $display("FAIL after_skip_dir: got %b want 1", dir_a); else passed++;
        checks++; if (pvs_a - p0 !== 0) $display("FAIL after_skip_pv: got %0d want 0", pvs_a - p0); else passed++;
        step_a(3'b001, 300);
        checks++; if (per_a !== (PEN ? 20'd300 : 20'd0)) $display("FAIL resume_period: got %0d want %0d", per_a, PEN ? 300 : 0); else passed++;
        step_a(3'b111, 300);
        checks++; if (faults_a - f0 !== 2) $display("FAIL inv_fault: got %0d want 2", faults_a - f0); else passed++;
        checks++; if (hv_a !== 1'b0) $display("FAIL inv_valid: got %b want 0", hv_a); else passed++;
        step_a(3'b101, 300);
        step_a(3'b100, 300);
        checks++; if (faults_a - f0 !== 2) $display("FAIL from_inv_fault: got %0d want 2", faults_a - f0); else passed++;
        checks++; if (pvs_a - p0 !== (PEN ? 1 : 0)) $display("FAIL from_inv_pv: got %0d want %0d", pvs_a - p0, PEN ? 1 : 0); else passed++;
        checks++; if ({hv_a, dir_a} !== 2'b11) $display("FAIL from_inv_state: got %b want 11", {hv_a, dir_a}); else passed++;
    endtask

    task automatic test_reset_mid;
        int f0;
        step_a(3'b110, 8);
        rst_n_a = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (h_a !== 3'b000) $display("FAIL midrst_h: got %b want 000", h_a); else passed++;
        f0 = faults_a;
        rst_n_a = 1'b1;
        repeat (D + 3) @(negedge clk);
        checks++; if (h_a !== 3'b110) $display("FAIL midrst_acq: got %b want 110", h_a); else passed++;
        checks++; if ({dir_a, 1'(faults_a - f0)} !== 2'b10) $display("FAIL midrst_unclassified: got %b want 10", {dir_a, 1'(faults_a - f0)}); else passed++;
    endtask

    task automatic test_stall;
        int p0;
        rst_n_b = 1'b0; raw_b = 3'b000;
        repeat (5) @(negedge clk);
        rst_n_b = 1'b1;
        step_b(3'b100, 40);
        p0 = pvs_b;
        step_b(3'b110, 255);
        step_b(3'b010, 256);
        // Spacing of 2^8-1 is the largest that still measures.
        checks++; if (per_b !== (PEN ? 8'd255 : 8'd0)) $display("FAIL max_period: got %0d want %0d", per_b, PEN ? 255 : 0); else passed++;
        checks++; if (st_b !== 1'b0) $display("FAIL max_stalled: got %b want 0", st_b); else passed++;
        step_b(3'b011, 300);
        checks++; if (st_b !== PEN) $display("FAIL stall_set: got %b want %b", st_b, PEN); else passed++;
        checks++; if (pvs_b - p0 !== (PEN ? 1 : 0)) $display("FAIL stall_suppress: got %0d want %0d", pvs_b - p0, PEN ? 1 : 0); else passed++;
        step_b(3'b001, 100);
        checks++; if (st_b !== 1'b0) $display("FAIL stall_clear: got %b want 0", st_b); else passed++;
        checks++; if (pvs_b - p0 !== (PEN ? 1 : 0)) $display("FAIL stall_first_step_pv: got %0d want %0d", pvs_b - p0, PEN ? 1 : 0); else passed++;
        step_b(3'b101, 100);
        checks++; if (per_b !== (PEN ? 8'd100 : 8'd0)) $display("FAIL stall_recover_period: got %0d want %0d", per_b, PEN ? 100 : 0); else passed++;
        checks++; if (pvs_b - p0 !== (PEN ? 2 : 0)) $display("FAIL stall_recover_pv: got %0d want %0d", pvs_b - p0, PEN ? 2 : 0); else passed++;
    endtask

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        raw_a = 3'b000; raw_b = 3'b000;
        @(negedge clk);
        test_reset;
        test_acquire;
        test_glitch;
        test_forward_reverse;
        test_skip_fault;
        test_reset_mid;
        test_stall;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
